// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider control path.
package div_pkg;
  localparam int   DIV_WIDTH = 32;
  localparam logic ALU_SUB   = 1'b1;
  localparam logic ALU_ADD   = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SUB   = 3'd2,
    TEST  = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } div_state_e;
endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: clears on load, bumps once per TEST, flags the last pass.
module div_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/div_ctrl.sv
// Sequencing FSM for the restoring divider: load, WIDTH x (sub, test), final shift, done.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Rem_sign,
  output logic             W_ctrl,
  output logic             ALU_op,
  output logic             Rem_write,
  output logic             Shift_left,
  output logic             Shift_in_bit,
  output logic             Final_shr,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter_cnt
);
  div_state_e state, state_n;
  logic       last;

  div_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (state == LOAD),
    .inc   (state == TEST),
    .cnt   (Iter_cnt),
    .last  (last)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = Start ? LOAD : IDLE;
      LOAD:    state_n = SUB;
      SUB:     state_n = TEST;
      TEST:    state_n = last ? FINAL : SUB;
      FINAL:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Only the TEST decisions look at Rem_sign; everything else decodes the state.
  always_comb begin
    W_ctrl       = 1'b0;
    ALU_op       = ALU_ADD;
    Rem_write    = 1'b0;
    Shift_left   = 1'b0;
    Shift_in_bit = 1'b0;
    Final_shr    = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (state)
      LOAD: begin
        W_ctrl = 1'b1;
        Busy   = 1'b1;
      end
      SUB: begin
        ALU_op    = ALU_SUB;
        Rem_write = 1'b1;
        Busy      = 1'b1;
      end
      TEST: begin
        Busy         = 1'b1;
        Shift_left   = 1'b1;
        ALU_op       = ALU_ADD;
        Rem_write    = Rem_sign;
        Shift_in_bit = ~Rem_sign;
      end
      FINAL: begin
        Final_shr = 1'b1;
        Busy      = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end
endmodule
